// File: rtl/tone_gen_pkg.sv
// rtl/tone_gen_pkg.sv - shared types and note table for the tone generator
package tone_gen_pkg;

  localparam int NUM_NOTES = 12;
  localparam logic [2:0] OCT_MUTE = 3'd7;
  localparam longint unsigned REF_HZ = 64'd10_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY
  } state_t;

  // Octave-0 half-periods in clocks at REF_HZ, C..B
  localparam logic [17:0] BASE [NUM_NOTES] = '{
    18'd152891, 18'd144309, 18'd136210, 18'd128566,
    18'd121350, 18'd114537, 18'd108110, 18'd102043,
    18'd96315,  18'd90909,  18'd85807,  18'd80991
  };

  function automatic logic [17:0] scale_base(input logic [17:0] b, input longint unsigned clk_hz);
    longint unsigned t;
    t = (64'(b) * clk_hz) / REF_HZ;
    return t[17:0];
  endfunction

endpackage

// File: rtl/tone_gen_enc.sv
// rtl/tone_gen_enc.sv - lowest-set-bit priority encoder for the note keys
module note_prio_enc
  import tone_gen_pkg::*;
(
  input  logic [11:0] keys,
  output logic        valid,
  output logic [3:0]  idx
);

  always_comb begin
    valid = 1'b0;
    idx   = 4'd0;
    // Scan downward so the lowest pressed key is written last and wins
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (keys[i]) begin
        valid = 1'b1;
        idx   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave note generator with key priority and octave shift
module tone_gen
  import tone_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  octave,
  input  logic [11:0] keys,
  input  logic        en,
  output logic        wave,
  output logic        note_active,
  output logic [3:0]  note_idx
);

  state_t      state;
  logic [11:0] keys_s;
  logic [2:0]  oct_s;
  logic        en_s;
  logic [3:0]  note_lat;
  logic [2:0]  oct_lat;
  logic [17:0] cnt;

  logic        key_valid;
  logic [3:0]  key_idx;
  logic [17:0] base_sel;
  logic [17:0] half_m1;
  logic        go;
  logic        changed;

  note_prio_enc u_enc (
    .keys  (keys_s),
    .valid (key_valid),
    .idx   (key_idx)
  );

  always_comb begin
    base_sel = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (key_idx == 4'(i)) base_sel = scale_base(BASE[i], 64'(CLK_HZ));
    end
  end

  assign half_m1 = (base_sel >> oct_s) - 18'd1;
  assign go      = en_s && key_valid && (oct_s != OCT_MUTE);
  assign changed = (key_idx != note_lat) || (oct_s != oct_lat);

  // The counter is loaded on entry to LOAD and keeps counting through it,
  // so LOAD is the first cycle of the first half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      keys_s      <= '0;
      oct_s       <= '0;
      en_s        <= 1'b0;
      note_lat    <= '0;
      oct_lat     <= '0;
      cnt         <= '0;
      wave        <= 1'b0;
      note_active <= 1'b0;
      note_idx    <= '0;
    end else begin
      keys_s <= keys;
      oct_s  <= octave;
      en_s   <= en;
      case (state)
        ST_IDLE: begin
          wave        <= 1'b0;
          note_active <= 1'b0;
          note_idx    <= '0;
          if (go) begin
            state       <= ST_LOAD;
            note_lat    <= key_idx;
            oct_lat     <= oct_s;
            cnt         <= half_m1;
            note_active <= 1'b1;
            note_idx    <= key_idx;
          end
        end
        ST_LOAD: begin
          cnt   <= cnt - 18'd1;
          state <= ST_PLAY;
        end
        ST_PLAY: begin
          if (!go) begin
            state       <= ST_IDLE;
            wave        <= 1'b0;
            note_active <= 1'b0;
            note_idx    <= '0;
            cnt         <= '0;
          end else if (changed) begin
            state    <= ST_LOAD;
            note_lat <= key_idx;
            oct_lat  <= oct_s;
            cnt      <= half_m1;
            wave     <= 1'b0;
            note_idx <= key_idx;
          end else if (cnt == 18'd0) begin
            wave <= ~wave;
            cnt  <= half_m1;
          end else begin
            cnt <= cnt - 18'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - self-checking bench for tone_gen
module tb_tone_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  octave;
  logic [11:0] keys;
  logic        en;
  logic        wave;
  logic        note_active;
  logic [3:0]  note_idx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int   cyc;
    logic val;
  } edge_t;
  edge_t exp_q[$];
  edge_t mon_e;
  logic  last_wave = 1'b0;

  typedef struct {
    logic [11:0] k;
    logic [2:0]  o;
    logic        e;
    logic        act;
    logic [3:0]  idx;
  } vec_t;
  vec_t vec[8];

  tone_gen #(.CLK_HZ(10_000_000)) dut (
    .clk         (clk),
    .rst         (rst),
    .octave      (octave),
    .keys        (keys),
    .en          (en),
    .wave        (wave),
    .note_active (note_active),
    .note_idx    (note_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int half_p(input int n, input int o);
    int b;
    case (n)
      0: b = 152891;  1: b = 144309;  2: b = 136210;  3: b = 128566;
      4: b = 121350;  5: b = 114537;  6: b = 108110;  7: b = 102043;
      8: b = 96315;   9: b = 90909;   10: b = 85807;  default: b = 80991;
    endcase
    return b >> o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every wave transition is matched against the next expected edge
  always @(negedge clk) begin
    if (wave !== last_wave) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_edge: wave=%0b at cycle %0d, no edge expected", wave, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("edge_cycle", cyc, mon_e.cyc);
        check("edge_level", int'(wave), int'(mon_e.val));
      end
      last_wave = wave;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] k, input logic [2:0] o, input logic e);
    keys   = k;
    octave = o;
    en     = e;
  endtask

  task automatic push(input int c, input logic v);
    edge_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_pending_edges"}, exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input int w, input int a, input int i);
    check({name, "_wave"}, int'(wave), w);
    check({name, "_active"}, int'(note_active), a);
    check({name, "_idx"}, int'(note_idx), i);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int h;
    int c;

    vec[0] = '{12'h000, 3'd0, 1'b1, 1'b0, 4'd0};
    vec[1] = '{12'h200, 3'd0, 1'b1, 1'b1, 4'd9};
    vec[2] = '{12'h011, 3'd0, 1'b1, 1'b1, 4'd0};
    vec[3] = '{12'h800, 3'd2, 1'b1, 1'b1, 4'd11};
    vec[4] = '{12'h800, 3'd7, 1'b1, 1'b0, 4'd0};
    vec[5] = '{12'h800, 3'd2, 1'b0, 1'b0, 4'd0};
    vec[6] = '{12'h0F0, 3'd1, 1'b1, 1'b1, 4'd4};
    vec[7] = '{12'h000, 3'd1, 1'b1, 1'b0, 4'd0};

    rst = 1'b1;
    drive(12'h200, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_out("reset", 0, 0, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(vec[i].k, vec[i].o, vec[i].e);
      step(3);
      check($sformatf("vec%0d_active", i), int'(note_active), int'(vec[i].act));
      check($sformatf("vec%0d_idx", i), int'(note_idx), int'(vec[i].idx));
      check($sformatf("vec%0d_wave", i), int'(wave), 0);
    end
    step(2);

    // A at octave 3: first rise 2 + half-period after the inputs change
    h = half_p(9, 3);
    c = cyc;
    drive(12'h200, 3'd3, 1'b1);
    push(c + h + 2, 1'b1);
    push(c + 2 * h + 2, 1'b0);
    push(c + 3 * h + 2, 1'b1);
    step(5);
    check_out("a_oct3", 0, 1, 9);
    drain("a_oct3", 3 * h + 100);

    // Octave change mid-play while wave is high: forced low, phase restarts
    h = half_p(9, 5);
    c = cyc;
    octave = 3'd5;
    push(c + 2, 1'b0);
    push(c + 2 + h, 1'b1);
    push(c + 2 + 2 * h, 1'b0);
    drain("a_oct5", 2 * h + 100);

    // Two keys pressed, lowest (C) wins, top octave
    h = half_p(0, 6);
    c = cyc;
    drive(12'h011, 3'd6, 1'b1);
    push(c + 2 + h, 1'b1);
    push(c + 2 + 2 * h, 1'b0);
    step(4);
    check_out("c_oct6", 0, 1, 0);
    drain("c_oct6", 2 * h + 100);

    drive(12'h011, 3'd7, 1'b1);
    step(2);
    check_out("mute_stop", 0, 0, 0);

    c = cyc;
    drive(12'h011, 3'd6, 1'b1);
    push(c + 2 + h, 1'b1);
    drain("c_restart", h + 100);

    // Disable while wave is high: low within two cycles
    c = cyc;
    en = 1'b0;
    push(c + 2, 1'b0);
    step(2);
    check_out("en_stop", 0, 0, 0);
    drain("en_stop", 10);

    // Reset with the counter at 500, then a full restart through LOAD
    h = half_p(9, 6);
    c = cyc;
    drive(12'h200, 3'd6, 1'b1);
    step(h - 499);
    rst = 1'b1;
    #1;
    check_out("mid_reset", 0, 0, 0);
    step(1);
    rst = 1'b0;
    c = cyc;
    push(c + h + 2, 1'b1);
    step(1);
    check_out("post_reset_sample", 0, 0, 0);
    step(1);
    check_out("post_reset_load", 0, 1, 9);
    drain("post_reset", h + 100);

    drive(12'h000, 3'd0, 1'b1);
    push(cyc + 2, 1'b0);
    step(3);
    check_out("final_idle", 0, 0, 0);
    drain("final_idle", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
